// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a 16:1 mux select, with a bounded hold time per grant
// and a one-cycle preempt pulse when a grant is ended only by timeout.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        gnt_valid,
    output logic        preempt
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] gnt_q, gnt_d;
    logic        gnt_valid_q, gnt_valid_d;
    logic        preempt_q, preempt_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  hold_q, hold_d;

    logic [3:0]  pick;
    logic [3:0]  idx;
    logic        timeout, dropped;

    // Scan downwards so the candidate closest to ptr is the last (winning) assignment.
    always_comb begin
        pick = ptr_q;
        idx  = ptr_q;
        for (int k = 15; k >= 0; k--) begin
            idx = ptr_q + 4'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    assign timeout = (hold_q == 8'(MAX_HOLD - 1));
    assign dropped = !req[sel_q];

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        preempt_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d     = StGrant;
                    sel_d       = pick;
                    gnt_d       = 16'b1 << pick;
                    gnt_valid_d = 1'b1;
                    hold_d      = 8'd0;
                end else begin
                    gnt_d       = 16'b0;
                    gnt_valid_d = 1'b0;
                end
            end
            StGrant: begin
                if (done || dropped || timeout) begin
                    state_d     = StIdle;
                    gnt_d       = 16'b0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = sel_q + 4'd1;
                    preempt_d   = timeout && !done && !dropped;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sel_q       <= 4'd0;
            gnt_q       <= 16'b0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            ptr_q       <= 4'd0;
            hold_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: two instances (MAX_HOLD 8 and 1) checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;

    logic [3:0]  sel0, sel1;
    logic [15:0] gnt0, gnt1;
    logic        val0, val1, pre0, pre1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.MAX_HOLD(8)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .sel(sel0), .gnt(gnt0), .gnt_valid(val0), .preempt(pre0)
    );

    mux_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .sel(sel1), .gnt(gnt1), .gnt_valid(val1), .preempt(pre1)
    );

    // Model state per instance
    int maxh  [2] = '{8, 1};
    bit m_busy[2];
    int m_own [2];
    int m_hold[2];
    int m_ptr [2];
    bit m_pre [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int j);
        bit to, dr;
        if (rst) begin
            m_busy[j] = 0; m_own[j] = 0; m_hold[j] = 0; m_ptr[j] = 0; m_pre[j] = 0;
        end else if (!m_busy[j]) begin
            m_pre[j] = 0;
            if (req != 16'h0) begin
                for (int k = 0; k < 16; k++) begin
                    if (req[(m_ptr[j] + k) % 16]) begin
                        m_own[j] = (m_ptr[j] + k) % 16;
                        break;
                    end
                end
                m_busy[j] = 1;
                m_hold[j] = 0;
            end
        end else begin
            to = (m_hold[j] == maxh[j] - 1);
            dr = !req[m_own[j]];
            if (done || dr || to) begin
                m_busy[j] = 0;
                m_ptr[j]  = (m_own[j] + 1) % 16;
                m_pre[j]  = to && !done && !dr;
            end else begin
                m_hold[j]++;
                m_pre[j] = 0;
            end
        end
    endtask

    task automatic compare_one(input int j, input logic [3:0] s, input logic [15:0] g,
                               input logic v, input logic p);
        logic [15:0] eg;
        eg = m_busy[j] ? (16'b1 << m_own[j]) : 16'b0;
        check($sformatf("gnt%0d", j), 32'(g), 32'(eg));
        check($sformatf("valid%0d", j), 32'(v), 32'(m_busy[j]));
        check($sformatf("preempt%0d", j), 32'(p), 32'(m_pre[j]));
        check($sformatf("sel%0d", j), 32'(s), 32'(m_own[j]));
        check($sformatf("onehot%0d", j), 32'($onehot0(g)), 32'd1);
        check($sformatf("gnt_sel%0d", j), 32'(g[s]), 32'(v));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_one(0, sel0, gnt0, val0, pre0);
        compare_one(1, sel1, gnt1, val1, pre1);
    endtask

    initial begin
        rst = 1'b1; req = 16'h0; done = 1'b0;
        cycle(); cycle();
        check("rst_gnt", 32'(gnt0), 32'h0);
        check("rst_sel", 32'(sel0), 32'h0);
        check("rst_valid", 32'(val0), 32'h0);
        check("rst_pre", 32'(pre0), 32'h0);

        // Single requester: 8-cycle grant, preempt, one idle cycle, regrant
        rst = 1'b0; req = 16'h0010;
        cycle();
        check("single_gnt", 32'(gnt0), 32'h0010);
        check("single_sel", 32'(sel0), 32'h4);
        cycle();
        check("mh1_gnt_released", 32'(gnt1), 32'h0);
        check("mh1_preempt", 32'(pre1), 32'h1);
        repeat (6) cycle();
        check("single_gnt_8th", 32'(gnt0), 32'h0010);
        cycle();
        check("single_timeout_gnt", 32'(gnt0), 32'h0);
        check("single_timeout_pre", 32'(pre0), 32'h1);
        cycle();
        check("single_regrant", 32'(gnt0), 32'h0010);
        check("single_regrant_pre", 32'(pre0), 32'h0);

        // Drop request: owner 4 releases without preempt, then 9 is granted
        req = 16'h0200;
        cycle();
        check("drop_gnt", 32'(gnt0), 32'h0);
        check("drop_pre", 32'(pre0), 32'h0);
        cycle();
        check("own9_sel", 32'(sel0), 32'h9);
        // Reset mid-grant, then arbitration from ptr=0
        rst = 1'b1;
        cycle();
        check("midrst_gnt", 32'(gnt0), 32'h0);
        check("midrst_sel", 32'(sel0), 32'h0);
        rst = 1'b0; req = 16'h0202;
        cycle();
        check("after_rst_sel", 32'(sel0), 32'h1);
        check("after_rst_gnt", 32'(gnt0), 32'h0002);

        // Early release by done: owner 3, then req 0009 wraps to 0
        req = 16'h0008;
        cycle();
        cycle();
        check("own3_sel", 32'(sel0), 32'h3);
        req = 16'h0009; done = 1'b1;
        cycle();
        check("done_gnt", 32'(gnt0), 32'h0);
        check("done_pre", 32'(pre0), 32'h0);
        done = 1'b0;
        cycle();
        check("wrap_gnt", 32'(gnt0), 32'h0001);

        // Fairness across the wrap with 8001 held
        req = 16'h8001;
        repeat (40) cycle();

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 16'($urandom);
                    1: req = 16'b1 << $urandom_range(0, 15);
                    2: req = 16'h0;
                    default: req = (16'b1 << $urandom_range(0, 15))
                                 | (16'b1 << $urandom_range(0, 15));
                endcase
            end
            done = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
